// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle over DATA_WIDTH
// cycles. Division by zero and signed overflow resolve in a single cycle.
// BusyE stalls the front of the pipe while an op is in flight; DoneE pulses
// for one cycle with ResultE valid.

module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  flush,
  output logic                  BusyE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] ResultE
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operation context
  logic [2:0]      r_op;
  logic [N-1:0]    r_b_mag;      // |B|: multiplicand for mul, divisor for div
  logic            r_neg_ab;     // sign of product / quotient
  logic            r_neg_a;      // sign of remainder
  logic [CW-1:0]   r_cnt;

  // Multiplier state: {partial sum, remaining multiplier bits}
  logic [2*N-1:0]  r_prod;

  // Divider state: partial remainder and dividend/quotient shift register
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_quo;

  logic [N-1:0]    r_result;

  // Operand decode from the EX-stage inputs
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [N-1:0]    w_a_mag;
  logic [N-1:0]    w_b_mag;
  logic            w_div_by_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [N-1:0]    w_fast_result;

  // Iteration datapath
  logic [N:0]      w_mul_sum;
  logic [2*N-1:0]  w_prod_next;
  logic [N:0]      w_div_shift;
  logic [N:0]      w_div_diff;
  logic            w_div_fits;
  logic [N-1:0]    w_rem_next;
  logic [N-1:0]    w_quo_next;

  // Final sign correction and result select
  logic [2*N-1:0]  w_prod_signed;
  logic [N-1:0]    w_quo_signed;
  logic [N-1:0]    w_rem_signed;
  logic [N-1:0]    w_final;

  logic            w_accept;
  logic            w_finish;

  // Signedness per funct3, operand magnitudes and fast-path detection
  always_comb begin
    w_is_div      = MulDivOpE[2];
    // Divides: bit0 selects unsigned. Multiplies: MULHU is fully unsigned,
    // MULHSU keeps A signed only.
    w_a_signed    = w_is_div ? ~MulDivOpE[0] : ~(MulDivOpE[1] & MulDivOpE[0]);
    w_b_signed    = w_is_div ? ~MulDivOpE[0] : ~MulDivOpE[1];
    w_a_neg       = w_a_signed & SrcAE[N-1];
    w_b_neg       = w_b_signed & SrcBE[N-1];
    w_a_mag       = w_a_neg ? -SrcAE : SrcAE;
    w_b_mag       = w_b_neg ? -SrcBE : SrcBE;

    w_div_by_zero = w_is_div & (SrcBE == '0);
    w_div_ovf     = w_is_div & ~MulDivOpE[0]
                  & (SrcAE == {1'b1, {(N-1){1'b0}}})
                  & (SrcBE == '1);
    w_fast        = w_div_by_zero | w_div_ovf;

    // bit1 selects remainder for divides
    if (w_div_by_zero) begin
      w_fast_result = MulDivOpE[1] ? SrcAE : '1;
    end else begin
      w_fast_result = MulDivOpE[1] ? '0 : SrcAE;
    end
  end

  // One shift-add step and one restoring-divide step per cycle
  always_comb begin
    w_mul_sum   = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_b_mag} : '0);
    w_prod_next = {w_mul_sum, r_prod[N-1:1]};

    // Partial remainder stays below the divisor, so the shifted value fits
    // in N+1 bits and the borrow out of the subtract decides the quotient bit.
    w_div_shift = {r_rem, r_quo[N-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    w_div_fits  = ~w_div_diff[N];
    w_rem_next  = w_div_fits ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
    w_quo_next  = {r_quo[N-2:0], w_div_fits};
  end

  // Apply result signs to the final iteration and pick the requested half
  always_comb begin
    w_prod_signed = r_neg_ab ? -w_prod_next : w_prod_next;
    w_quo_signed  = r_neg_ab ? -w_quo_next  : w_quo_next;
    w_rem_signed  = r_neg_a  ? -w_rem_next  : w_rem_next;

    if (r_op[2]) begin
      w_final = r_op[1] ? w_rem_signed : w_quo_signed;
    end else begin
      w_final = (r_op[1:0] == 2'b00) ? w_prod_signed[N-1:0] : w_prod_signed[2*N-1:N];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, op acceptance and stall request
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and a latch is never inferred.
    w_state_next = r_state;
    w_accept     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (StartE && !flush) begin
          w_accept     = 1'b1;
          w_state_next = w_fast ? S_DONE : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (r_cnt == LAST_ITER) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A redirect squashes whatever is in flight
    if (flush) begin
      w_state_next = S_IDLE;
    end

    w_finish = (r_state == S_COMPUTE) && (r_cnt == LAST_ITER) && !flush;
    BusyE    = !rst && (((r_state == S_IDLE) && StartE && !flush) || (r_state == S_COMPUTE));
  end

  // Operand latch, iteration registers and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_b_mag  <= '0;
      r_neg_ab <= 1'b0;
      r_neg_a  <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= MulDivOpE;
      r_b_mag  <= w_b_mag;
      r_neg_ab <= w_a_neg ^ w_b_neg;
      r_neg_a  <= w_a_neg;
      r_cnt    <= '0;
      r_prod   <= {{N{1'b0}}, w_a_mag};
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      if (w_fast) begin
        r_result <= w_fast_result;
      end
    end else if (r_state == S_COMPUTE) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op[2]) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end else begin
        r_prod <= w_prod_next;
      end
      // A flushed op never reaches DONE, so the held result is left alone
      if (w_finish) begin
        r_result <= w_final;
      end
    end
  end

  assign DoneE   = (r_state == S_DONE);
  assign ResultE = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, flush and
// reset during compute, back-to-back timing, then randomized ops compared
// against an arithmetic reference model.

module tb_muldiv_unit;

  localparam int N = 32;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        flush;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_done_cyc = 0;
  logic [31:0] exp_last = '0;

  muldiv_unit #(.DATA_WIDTH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .flush     (flush),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural RV32M result, computed with plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    logic        ovf;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op in the next cycle, hold StartE until DoneE, check result and timing
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    logic [31:0] got;
    int          busy_n;
    int          done_at;
    int          lat;
    exp     = ref_model(op, a, b);
    lat     = ref_fast(op, a, b) ? 1 : N + 1;
    busy_n  = 0;
    done_at = -1;
    got     = 'x;
    @(posedge clk); #1;
    StartE    = 1'b1;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    for (int c = 0; c < 2 * N + 10; c++) begin
      @(negedge clk);
      if (DoneE) begin
        done_at = c;
        got     = ResultE;
        check({tag, "_busy_in_done"}, 32'(BusyE), 32'd0);
        break;
      end
      if (BusyE) busy_n++;
      @(posedge clk); #1;
    end
    StartE = 1'b0;
    last_done_cyc = cyc;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    check({tag, "_result"}, got, exp);
    exp_last = exp;
  endtask

  // Count DoneE pulses over a window where none may occur
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (DoneE) pulses++;
    end
    check({tag, "_no_done"}, 32'(pulses), 32'd0);
    check({tag, "_result_held"}, ResultE, exp_last);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t1;
    rst       = 1'b1;
    StartE    = 1'b1;
    MulDivOpE = 3'd0;
    SrcAE     = 32'd5;
    SrcBE     = 32'd6;
    flush     = 1'b0;

    // Reset: BusyE suppressed while rst is high, even with StartE asserted
    @(negedge clk);
    check("rst_busy", 32'(BusyE), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(DoneE), 32'd0);
    check("rst_result", ResultE, 32'd0);
    check("rst_idle_busy", 32'(BusyE), 32'd0);

    // Directed vectors
    run_op("mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh_min_min",  3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhsu_ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_100_7",    3'd5, 32'd100,        32'd7);
    run_op("remu_100_7",    3'd7, 32'd100,        32'd7);
    run_op("div_5_0",       3'd4, 32'd5,          32'd0);
    run_op("rem_5_0",       3'd6, 32'd5,          32'd0);
    run_op("divu_5_0",      3'd5, 32'd5,          32'd0);
    run_op("div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("divu_min_m1",   3'd5, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("div_min_1",     3'd4, 32'h8000_0000,  32'd1);

    // Flush during compute: back to IDLE, no DoneE, result held
    @(posedge clk); #1;
    StartE    = 1'b1;
    MulDivOpE = 3'd5;
    SrcAE     = 32'd1_000_000;
    SrcBE     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush  = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(BusyE), 32'd0);
    check("flush_done", 32'(DoneE), 32'd0);
    check("flush_result", ResultE, exp_last);
    expect_quiet("flush", 2 * N);
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4);

    // flush together with StartE in IDLE: op not accepted
    @(posedge clk); #1;
    StartE    = 1'b1;
    flush     = 1'b1;
    MulDivOpE = 3'd0;
    SrcAE     = 32'd9;
    SrcBE     = 32'd9;
    @(negedge clk);
    check("flush_start_busy", 32'(BusyE), 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0;
    flush  = 1'b0;
    expect_quiet("flush_start", 2 * N);

    // Reset during compute
    @(posedge clk); #1;
    StartE    = 1'b1;
    MulDivOpE = 3'd0;
    SrcAE     = 32'h1234;
    SrcBE     = 32'h5678;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(BusyE), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    check("midrst_busy_after", 32'(BusyE), 32'd0);
    check("midrst_done", 32'(DoneE), 32'd0);
    check("midrst_result", ResultE, 32'd0);
    exp_last = '0;
    expect_quiet("midrst", 2 * N);

    // Back-to-back: second op starts the cycle after DONE
    run_op("b2b_2x3", 3'd0, 32'd2, 32'd3);
    t1 = last_done_cyc;
    run_op("b2b_4x5", 3'd0, 32'd4, 32'd5);
    check("b2b_spacing", 32'(last_done_cyc - t1), 32'(N + 2));

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
